// File: rtl/stopwatch_ctrl_if.sv
// Button, BCD-counter and display signals of the stopwatch controller.
// master = button/counter side, slave = stopwatch_ctrl.
interface stopwatch_ctrl_if;
    logic       btn_start;
    logic       btn_lap;
    logic       btn_clear;
    logic [3:0] bcd_ten;
    logic [3:0] bcd_one;
    logic       cnt_en;
    logic       cnt_clr;
    logic [3:0] disp_ten;
    logic [3:0] disp_one;
    logic [1:0] state;
    logic       done;

    modport master (
        output btn_start, btn_lap, btn_clear, bcd_ten, bcd_one,
        input  cnt_en, cnt_clr, disp_ten, disp_one, state, done
    );

    modport slave (
        input  btn_start, btn_lap, btn_clear, bcd_ten, bcd_one,
        output cnt_en, cnt_clr, disp_ten, disp_one, state, done
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Start/pause/clear controller driving an external two-digit BCD counter and its display.
// Optional macro LAP_EN adds the lap button that freezes the display; without it btn_lap is ignored.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 50_000_000
) (
    input logic            clk,
    input logic            reset,
    stopwatch_ctrl_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] RUN   = 2'b01;
    localparam logic [1:0] PAUSE = 2'b10;
    localparam logic [1:0] DONE  = 2'b11;

    localparam int              PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

    localparam int BTN_START = 0;
    localparam int BTN_CLEAR = 1;
`ifdef LAP_EN
    localparam int BTN_LAP   = 2;
    localparam int NBTN      = 3;
`else
    localparam int NBTN      = 2;
`endif

    logic [NBTN-1:0] btn_in;
    logic [NBTN-1:0] btn_p0;
    logic [NBTN-1:0] btn_p1;
    logic [NBTN-1:0] btn_p2;
    logic [NBTN-1:0] armed;
    logic [NBTN-1:0] evt_p3;
    logic            warm_p0;
    logic            warm_p1;

    logic [1:0]      state;
    logic [PW-1:0]   presc;
    logic            tick;
    logic            clr_pulse;
    logic            hold;
    logic [3:0]      disp_ten;
    logic [3:0]      disp_one;

    logic            start_evt;
    logic            clear_evt;
    logic            at_top;
    logic            terminal;

`ifdef LAP_EN
    assign btn_in = {bus.btn_lap, bus.btn_clear, bus.btn_start};
`else
    assign btn_in = {bus.btn_clear, bus.btn_start};
`endif

    // Sync stage: p0/p1 synchronize, p2 delays for edge detect, p3 registers the event.
    // A button only arms once it has been seen low on a filled pipeline, so a button
    // held through reset release produces no event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_p0  <= '0;
            btn_p1  <= '0;
            btn_p2  <= '0;
            evt_p3  <= '0;
            armed   <= '0;
            warm_p0 <= 1'b0;
            warm_p1 <= 1'b0;
        end else begin
            btn_p0  <= btn_in;
            btn_p1  <= btn_p0;
            btn_p2  <= btn_p1;
            warm_p0 <= 1'b1;
            warm_p1 <= warm_p0;
            armed   <= armed | ({NBTN{warm_p1}} & ~btn_p1);
            evt_p3  <= btn_p1 & ~btn_p2 & armed;
        end
    end

    assign start_evt = evt_p3[BTN_START];
    assign clear_evt = evt_p3[BTN_CLEAR];
    assign at_top    = (presc == PRESC_MAX);
    assign terminal  = (bus.bcd_ten == 4'd9) && (bus.bcd_one == 4'd9);

    // Control stage: clear beats start, start beats counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            presc     <= '0;
            tick      <= 1'b0;
            clr_pulse <= 1'b0;
        end else begin
            tick      <= 1'b0;
            clr_pulse <= 1'b0;
            if (clear_evt) begin
                state     <= IDLE;
                presc     <= '0;
                clr_pulse <= 1'b1;
            end else if (start_evt) begin
                case (state)
                    IDLE, PAUSE: state <= RUN;
                    RUN:         state <= PAUSE;
                    default:     state <= state;
                endcase
            end else if (state == RUN) begin
                if (at_top) begin
                    presc <= '0;
                    if (terminal)
                        state <= DONE;
                    else
                        tick <= 1'b1;
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

`ifdef LAP_EN
    logic lap_evt;
    assign lap_evt = evt_p3[BTN_LAP];

    // A lap event loses to clear and start in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold <= 1'b0;
        end else if (clear_evt) begin
            hold <= 1'b0;
        end else if (!start_evt && lap_evt) begin
            hold <= (state == RUN) ? ~hold : 1'b0;
        end
    end
`else
    assign hold = 1'b0;
`endif

    // Display stage: digits pass through unchanged, including non-BCD codes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_ten <= 4'd0;
            disp_one <= 4'd0;
        end else if (!hold) begin
            disp_ten <= bus.bcd_ten;
            disp_one <= bus.bcd_one;
        end
    end

    assign bus.cnt_en   = tick;
    assign bus.cnt_clr  = clr_pulse;
    assign bus.disp_ten = disp_ten;
    assign bus.disp_one = disp_one;
    assign bus.state    = state;
    assign bus.done     = (state == DONE);

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter: TICK_DIV, default 50_000_000, clk cycles per count tick (valid range >= 2).
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 btn_start  input  1  start/stop button, asynchronous level.
REQ-005 btn_lap  input  1  lap (display freeze) button, asynchronous level.
REQ-006 btn_clear  input  1  clear button, asynchronous level.
REQ-007 bcd_ten  input  4  tens digit from the external two-digit BCD counter.
REQ-008 bcd_one  input  4  ones digit from the external two-digit BCD counter.
REQ-009 cnt_en  output  1  one-cycle increment pulse to the counter.
REQ-010 cnt_clr  output  1  one-cycle synchronous clear pulse to the counter.
REQ-011 disp_ten  output  4  tens digit to the 7-segment decoder.
REQ-012 disp_one  output  4  ones digit to the 7-segment decoder.
REQ-013 state  output  2  current FSM state encoding.
REQ-014 done  output  1  high while state is DONE.

Function
REQ-015 Each button SHALL pass through a two-flop synchronizer plus a third delay flop; event = sync2 AND NOT sync3, exactly one cycle per rising button edge.
REQ-016 A button rising before clk edge k SHALL take effect on state/outputs at edge k+3; a held button SHALL generate no further events.
REQ-017 FSM states SHALL be IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-018 Transitions: IDLE+start->RUN; RUN+start->PAUSE; PAUSE+start->RUN; DONE+start ignored; clear from any state->IDLE.
REQ-019 Same-cycle event priority SHALL be clear > start > lap; lower-priority events that cycle are discarded.
REQ-020 Clear event SHALL assert cnt_clr for exactly one cycle, zero the prescaler and clear the hold flag.
REQ-021 Prescaler SHALL count 0..TICK_DIV-1 only in RUN, hold its value in PAUSE, wrap to 0 after TICK_DIV-1.
REQ-022 In RUN, when prescaler = TICK_DIV-1 and {bcd_ten,bcd_one} != 9,9, cnt_en SHALL pulse for one cycle; cnt_en is low in all other cycles.
REQ-023 In RUN, when prescaler = TICK_DIV-1 and {bcd_ten,bcd_one} = 9,9, cnt_en SHALL stay low and FSM SHALL enter DONE (no wrap to 00).
REQ-024 Pausing SHALL not lose a tick phase: after RUN->PAUSE->RUN, the next cnt_en occurs after the remaining prescaler cycles.
REQ-025 When hold flag is 0, disp_ten/disp_one SHALL register bcd_ten/bcd_one every cycle (one-cycle latency); when 1, they SHALL keep their value.
REQ-026 BCD inputs > 9 SHALL be passed through to the display unchanged and never match the 9,9 terminal check.

Reset
REQ-027 Reset SHALL force state=IDLE, cnt_en=0, cnt_clr=0, done=0, disp_ten=0, disp_one=0, prescaler=0, hold=0, all synchronizer flops=0, asynchronously.
REQ-028 Reset asserted mid-RUN SHALL abort immediately; after release the block SHALL wait in IDLE with no cnt_en pulses.
REQ-029 A button already high at reset release SHALL not produce an event until released and pressed again.

Configuration
REQ-030 Macro LAP_EN: when defined, a lap event in RUN toggles the hold flag; a lap event in IDLE, PAUSE or DONE clears it.
REQ-031 Without LAP_EN, btn_lap SHALL be ignored, hold SHALL stay 0 and display always follows the counter.

Verification
REQ-032 TICK_DIV=4; reset, press start -> state=01 at edge k+3, cnt_en pulses every 4 cycles, counter 00->05 after 20 cycles.
REQ-033 Running at count 37, press start -> state=10, no cnt_en, prescaler held; press start -> state=01, first cnt_en after remaining cycles, count 38.
REQ-034 Counter at 9,9 in RUN with prescaler=3 -> cnt_en stays 0, state=11, done=1; start press ignored; clear -> cnt_clr one cycle, state=00.
REQ-035 LAP_EN defined, running at 12, press lap -> display frozen at 12 while counter reaches 20; press lap -> display shows 20 one cycle later.
REQ-036 Start and clear rising in same cycle while RUN -> state=00, cnt_clr=1 for one cycle, no transition to PAUSE.
REQ-037 Assert reset while RUN at count 45 with hold=1 -> all outputs 0 immediately, state=00; after release, no cnt_en without a start press.
